// File: rtl/nbit_4x1_multiplexer.sv
`default_nettype none
// ============================================================================
// Module   : nbit_4x1_multiplexer
// Purpose  : N-bit 4-to-1 multiplexer. It has a zero-latency combinational
//            output and a registered capture path. The capture path stores
//            the mux output, the select value and two status flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1  rising-edge clock for all registers
//   rst      in   1  asynchronous, active-high reset
//   A..D     in   N  data inputs, chosen by S = 00 / 01 / 10 / 11
//   S        in   2  select
//   en       in   1  capture enable for the registered path
//   Y        out  N  combinational mux output
//   Y_reg    out  N  Y captured on an enabled edge
//   S_reg    out  2  S captured together with Y_reg
//   valid    out  1  high for the cycle that follows each capture
//   sel_chg  out  1  high after a capture whose S differs from the old S_reg
//   P_reg    out  1  even-parity XOR of the captured Y
//                    (present only when NBIT_MUX_PARITY_EN is defined)
// Configuration macro: NBIT_MUX_PARITY_EN
// ============================================================================
module nbit_4x1_multiplexer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] C,
  input  logic [N-1:0] D,
  input  logic [1:0]   S,
  input  logic         en,
  output logic [N-1:0] Y,
  output logic [N-1:0] Y_reg,
  output logic [1:0]   S_reg,
  output logic         valid,
  output logic         sel_chg
`ifdef NBIT_MUX_PARITY_EN
  ,
  output logic         P_reg
`endif
);

  logic [N-1:0] y_reg_d, y_reg_q;
  logic [1:0]   s_reg_d, s_reg_q;
  logic         valid_d, valid_q;
  logic         sel_chg_d, sel_chg_q;

  // Combinational mux. A select that holds X or Z falls through to the
  // default branch, so the output is all zeros.
  always_comb begin
    Y = '0;
    case (S)
      2'b00:   Y = A;
      2'b01:   Y = B;
      2'b10:   Y = C;
      2'b11:   Y = D;
      default: Y = '0;
    endcase
  end

  // Next-state logic for the capture path. Y_reg and S_reg keep their value
  // when en is low. The flags are single-cycle pulses tied to a capture.
  always_comb begin
    y_reg_d   = y_reg_q;
    s_reg_d   = s_reg_q;
    valid_d   = 1'b0;
    sel_chg_d = 1'b0;
    if (en) begin
      y_reg_d   = Y;
      s_reg_d   = S;
      valid_d   = 1'b1;
      sel_chg_d = (S != s_reg_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg_q   <= '0;
      s_reg_q   <= 2'b00;
      valid_q   <= 1'b0;
      sel_chg_q <= 1'b0;
    end else begin
      y_reg_q   <= y_reg_d;
      s_reg_q   <= s_reg_d;
      valid_q   <= valid_d;
      sel_chg_q <= sel_chg_d;
    end
  end

  assign Y_reg   = y_reg_q;
  assign S_reg   = s_reg_q;
  assign valid   = valid_q;
  assign sel_chg = sel_chg_q;

`ifdef NBIT_MUX_PARITY_EN
  logic p_reg_d, p_reg_q;

  // Parity is captured under the same enable as Y_reg, so the two stay
  // consistent with each other.
  always_comb begin
    p_reg_d = p_reg_q;
    if (en) begin
      p_reg_d = ^Y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg_q <= 1'b0;
    end else begin
      p_reg_q <= p_reg_d;
    end
  end

  assign P_reg = p_reg_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nbit_4x1_multiplexer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nbit_4x1_multiplexer
// Purpose  : Self-checking bench for nbit_4x1_multiplexer (N = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nbit_4x1_multiplexer;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         clk_on = 1'b0;
  logic         rst;
  logic [N-1:0] A, B, C, D, Y, Y_reg;
  logic [1:0]   S, S_reg;
  logic         en, valid, sel_chg;
`ifdef NBIT_MUX_PARITY_EN
  logic         P_reg;
`endif

  int checks = 0;
  int errors = 0;

  // The clock only runs once clk_on is set. This lets the combinational
  // checks run with no clock edges at all.
  always #5 if (clk_on) clk = ~clk;

  nbit_4x1_multiplexer #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .C       (C),
    .D       (D),
    .S       (S),
    .en      (en),
    .Y       (Y),
    .Y_reg   (Y_reg),
    .S_reg   (S_reg),
    .valid   (valid),
    .sel_chg (sel_chg)
`ifdef NBIT_MUX_PARITY_EN
    ,
    .P_reg   (P_reg)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference selection: the input whose position in {A,B,C,D} equals S.
  function automatic logic [N-1:0] pick(input logic [1:0] s, input logic [N-1:0] a,
                                        input logic [N-1:0] b, input logic [N-1:0] c,
                                        input logic [N-1:0] d);
    logic [N-1:0] din [4];
    din[0] = a; din[1] = b; din[2] = c; din[3] = d;
    return din[s];
  endfunction

  typedef struct {
    logic [1:0] s;
    logic [3:0] a, b, c, d;
    logic [3:0] y;
  } vec_t;

  vec_t vecs [8];

  // Reference model state for the capture path.
  logic [N-1:0] m_yreg;
  logic [1:0]   m_sreg;
  logic         m_valid, m_sel, m_par;

  initial begin
    vecs[0] = '{2'b00, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    vecs[1] = '{2'b01, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0100};
    vecs[2] = '{2'b10, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    vecs[3] = '{2'b11, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001};
    vecs[4] = '{2'b00, 4'hF,    4'h0,    4'h0,    4'h0,    4'hF};
    vecs[5] = '{2'b11, 4'h0,    4'h0,    4'h0,    4'hA,    4'hA};
    vecs[6] = '{2'b10, 4'h5,    4'h6,    4'h9,    4'h3,    4'h9};
    vecs[7] = '{2'b01, 4'hC,    4'h7,    4'hE,    4'h1,    4'h7};

    // Reset state. The clock is stopped, so only the async reset acts.
    rst = 1'b1; en = 1'b0; S = 2'b00;
    A = '0; B = '0; C = '0; D = '0;
    #3;
    chk("rst_y_reg", Y_reg, 0);
    chk("rst_s_reg", S_reg, 0);
    chk("rst_valid", valid, 0);
    chk("rst_sel_chg", sel_chg, 0);

    // Combinational table with no clock edges. Reset is still held, and
    // Y must keep working while reset is asserted.
    for (int i = 0; i < 8; i++) begin
      S = vecs[i].s; A = vecs[i].a; B = vecs[i].b; C = vecs[i].c; D = vecs[i].d;
      #10;
      chk($sformatf("table_y[%0d]", i), Y, vecs[i].y);
    end
    chk("noclk_y_reg", Y_reg, 0);

    // First capture after reset release: S=10 with the one-hot data.
    A = 4'b1000; B = 4'b0100; C = 4'b0010; D = 4'b0001; S = 2'b10; en = 1'b1;
    rst = 1'b0;
    #2 clk_on = 1'b1;
    @(posedge clk); #1;
    chk("cap1_y_reg", Y_reg, 4'b0010);
    chk("cap1_s_reg", S_reg, 2'b10);
    chk("cap1_valid", valid, 1);
    chk("cap1_sel_chg", sel_chg, 1);

    // Hold for 3 cycles with en low while S and the data change.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b0;
      A = N'($urandom); B = N'($urandom); C = N'($urandom); D = N'($urandom);
      S = 2'($urandom);
      #1 chk("hold_y_track", Y, pick(S, A, B, C, D));
      @(posedge clk); #1;
      chk("hold_y_reg", Y_reg, 4'b0010);
      chk("hold_s_reg", S_reg, 2'b10);
      chk("hold_valid", valid, 0);
      chk("hold_sel_chg", sel_chg, 0);
    end

    // Two back-to-back captures with S=11: the change flag pulses once.
    @(negedge clk);
    en = 1'b1; S = 2'b11; D = 4'h6;
    @(posedge clk); #1;
    chk("s11a_sel_chg", sel_chg, 1);
    chk("s11a_y_reg", Y_reg, 4'h6);
    @(negedge clk);
    D = 4'h9;
    @(posedge clk); #1;
    chk("s11b_sel_chg", sel_chg, 0);
    chk("s11b_valid", valid, 1);
    chk("s11b_y_reg", Y_reg, 4'h9);

    // Assert reset between edges. The outputs clear before the next edge,
    // and Y still follows the inputs.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_y_reg", Y_reg, 0);
    chk("midrst_s_reg", S_reg, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_sel_chg", sel_chg, 0);
    chk("midrst_y", Y, 4'h9);

    // First capture after reset with S=00. It compares against S_reg=00,
    // so no change is flagged.
    @(negedge clk);
    rst = 1'b0; S = 2'b00; A = 4'h3; en = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", valid, 1);
    chk("post_rst_sel_chg", sel_chg, 0);
    chk("post_rst_y_reg", Y_reg, 4'h3);
    m_yreg = 4'h3; m_sreg = 2'b00; m_par = 1'b0;

`ifdef NBIT_MUX_PARITY_EN
    @(negedge clk);
    A = 4'b0111;
    @(posedge clk); #1;
    chk("par_0111", P_reg, 1);
    @(negedge clk);
    A = 4'b0011;
    @(posedge clk); #1;
    chk("par_0011", P_reg, 0);
    m_yreg = 4'b0011;
`endif

    // Randomized run checked against the reference model.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      A = N'($urandom); B = N'($urandom); C = N'($urandom); D = N'($urandom);
      S = 2'($urandom);
      en = ($urandom_range(0, 3) != 0);
      #1 chk("rnd_y", Y, pick(S, A, B, C, D));
      if (en) begin
        m_sel   = (S != m_sreg);
        m_yreg  = pick(S, A, B, C, D);
        m_sreg  = S;
        m_valid = 1'b1;
        m_par   = ^m_yreg;
      end else begin
        m_sel   = 1'b0;
        m_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("rnd_y_reg", Y_reg, m_yreg);
      chk("rnd_s_reg", S_reg, m_sreg);
      chk("rnd_valid", valid, m_valid);
      chk("rnd_sel_chg", sel_chg, m_sel);
`ifdef NBIT_MUX_PARITY_EN
      chk("rnd_p_reg", P_reg, m_par);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
